// File: rtl/slc3_br_pkg.sv
// rtl/slc3_br_pkg.sv - shared types and constants for SLC-3 branch resolution
// Contents: branch FSM state enum, NZP bit indices, one-hot cc codes,
//           and a helper that tells whether a cc value is one-hot.
package slc3_br_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } br_state_e;

    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int P_BIT = 0;

    localparam logic [2:0] CC_N = 3'(1 << N_BIT);
    localparam logic [2:0] CC_Z = 3'(1 << Z_BIT);
    localparam logic [2:0] CC_P = 3'(1 << P_BIT);

    function automatic logic cc_is_onehot(input logic [2:0] c);
        return (c == CC_N) || (c == CC_Z) || (c == CC_P);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that holds at all-ones
// Ports: clk, reset (sync, active-high), inc (count enable), count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// rtl/br_resolve_ctrl.sv - SLC-3 BR resolution controller with NZP load gating
// Ports: clk, reset (sync, active-high)
//        ld_cc_req -> ld_cc       : cc register load enable pass-through
//        cc[2:0]                  : NZP register value {n,z,p}
//        br_valid/br_ready        : branch request handshake
//        br_mask[2:0], br_target  : captured on accept
//        br_done, br_taken, pc_ld, pc_next, cc_err : decision to control FSM
//        br_cnt, taken_cnt        : saturating statistics
module br_resolve_ctrl
    import slc3_br_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_cc_req,
    output logic             ld_cc,
    input  logic [2:0]       cc,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_mask,
    input  logic [15:0]      br_target,
    output logic             br_done,
    output logic             br_taken,
    output logic             pc_ld,
    output logic [15:0]      pc_next,
    output logic             cc_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e   state;
    br_state_e   state_next;
    logic [2:0]  mask_q;
    logic [15:0] pc_q;
    logic        taken_q;
    logic        err_q;
    logic        accept;

    // The cc register is never stalled by branch resolution.
    assign ld_cc = ld_cc_req & ~reset;

    always_comb begin
        state_next = state;
        br_ready   = 1'b0;
        br_done    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    accept = 1'b1;
                    // A cc write landing on this edge makes cc stale for one more cycle.
                    state_next = ld_cc_req ? WAIT : EVAL;
                end
            end
            WAIT: begin
                if (!ld_cc_req) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                state_next = RESP;
            end
            RESP: begin
                br_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mask_q  <= 3'b000;
            pc_q    <= 16'h0000;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                mask_q <= br_mask;
                pc_q   <= br_target;
            end
            if (state == EVAL) begin
                taken_q <= |(mask_q & cc);
                err_q   <= ~cc_is_onehot(cc);
            end
        end
    end

    assign br_taken = br_done & taken_q;
    assign pc_ld    = br_done & taken_q;
    assign cc_err   = br_done & err_q;
    assign pc_next  = pc_q;

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_done),
        .count (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_ld),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// tb/tb_br_resolve_ctrl.sv - self-checking bench for br_resolve_ctrl
module tb_br_resolve_ctrl;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ld_cc_req = 1'b0;
    logic             ld_cc;
    logic [2:0]       cc_reg;
    logic [2:0]       cc_bus = 3'b000;
    logic             br_valid = 1'b0;
    logic             br_ready;
    logic [2:0]       br_mask = 3'b000;
    logic [15:0]      br_target = 16'h0000;
    logic             br_done;
    logic             br_taken;
    logic             pc_ld;
    logic [15:0]      pc_next;
    logic             cc_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    br_resolve_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_cc_req (ld_cc_req),
        .ld_cc     (ld_cc),
        .cc        (cc_reg),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_mask   (br_mask),
        .br_target (br_target),
        .br_done   (br_done),
        .br_taken  (br_taken),
        .pc_ld     (pc_ld),
        .pc_next   (pc_next),
        .cc_err    (cc_err),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    // NZP register driven through the DUT's load enable
    always @(posedge clk) begin
        if (reset) cc_reg <= 3'b000;
        else if (ld_cc) cc_reg <= cc_bus;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: a branch is either absent, waiting for cc to settle,
    // due to sample cc at the next edge, or being reported.
    int          m_stage;
    bit          m_ready, m_done, m_taken, m_err;
    logic [2:0]  m_mask;
    logic [15:0] m_pc;
    int          m_bc, m_tc;

    always @(posedge clk) begin
        if (reset) begin
            m_stage = 0; m_ready = 1; m_done = 0; m_taken = 0; m_err = 0;
            m_mask = 3'b000; m_pc = 16'h0000; m_bc = 0; m_tc = 0;
        end else if (m_done) begin
            if (m_bc < MAXC) m_bc++;
            if (m_taken && m_tc < MAXC) m_tc++;
            m_done = 0; m_taken = 0; m_err = 0; m_ready = 1;
        end else if (m_ready && br_valid) begin
            m_mask = br_mask; m_pc = br_target; m_ready = 0;
            m_stage = ld_cc_req ? 1 : 2;
        end else if (m_stage == 1) begin
            if (!ld_cc_req) m_stage = 2;
        end else if (m_stage == 2) begin
            m_taken = 0;
            for (int b = 0; b < 3; b++) if (m_mask[b] && cc_reg[b]) m_taken = 1;
            m_err = ($countones(cc_reg) != 1);
            m_done = 1; m_stage = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld_cc", ld_cc, ld_cc_req & ~reset);
            chk("br_ready", br_ready, m_ready);
            chk("br_done", br_done, m_done);
            chk("br_taken", br_taken, m_done & m_taken);
            chk("pc_ld", pc_ld, m_done & m_taken);
            chk("cc_err", cc_err, m_done & m_err);
            chk("pc_next", pc_next, m_pc);
            chk("br_cnt", br_cnt, m_bc);
            chk("taken_cnt", taken_cnt, m_tc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cc(input logic [2:0] v);
        ld_cc_req = 1'b1; cc_bus = v;
        step();
        ld_cc_req = 1'b0;
    endtask

    // Issue one branch; hz puts ld_cc_req on the accept cycle, n_hold keeps it
    // for that many further cycles. e_lat is the edge (after accept edge T)
    // at which br_done is sampled high.
    task automatic do_br(input logic [2:0] mask, input logic [15:0] tgt, input bit hz,
                         input logic [2:0] bus, input int n_hold, input bit e_taken,
                         input bit e_err, input int e_lat, input string nm);
        int w;
        int k;
        w = 0;
        br_valid = 1'b1; br_mask = mask; br_target = tgt;
        while (!br_ready && w < 20) begin step(); w++; end
        chk({nm, "_ready_timeout"}, w < 20, 1);
        ld_cc_req = hz; cc_bus = bus;
        step();
        br_valid = 1'b0;
        k = 0;
        while (!br_done && k < 12) begin
            ld_cc_req = hz && (k < n_hold);
            step();
            k++;
        end
        ld_cc_req = 1'b0;
        chk({nm, "_done_seen"}, br_done, 1);
        chk({nm, "_latency"}, k + 1, e_lat);
        chk({nm, "_taken"}, br_taken, e_taken);
        chk({nm, "_pc_ld"}, pc_ld, e_taken);
        chk({nm, "_cc_err"}, cc_err, e_err);
        chk({nm, "_pc_next"}, pc_next, tgt);
        step();
    endtask

    initial begin
        int first_done;
        int second_done;
        int n_done;
        reset = 1'b1;
        step(); step();
        chk_en = 1'b1;
        reset = 1'b0;
        step();
        chk("rst_ready", br_ready, 1);
        chk("rst_pc_next", pc_next, 16'h0000);
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_done", br_done, 0);

        // cc still 000 from reset
        do_br(3'b111, 16'h3010, 0, 3'b000, 0, 0, 1, 2, "cc000");
        chk("cc000_br_cnt", br_cnt, 1);
        chk("cc000_taken_cnt", taken_cnt, 0);

        load_cc(3'b010);
        step(); step();
        do_br(3'b010, 16'h3020, 0, 3'b000, 0, 1, 0, 2, "brz");

        load_cc(3'b001);
        do_br(3'b100, 16'h3030, 1, 3'b100, 0, 1, 0, 3, "hazard");
        load_cc(3'b001);
        do_br(3'b100, 16'h3040, 0, 3'b000, 0, 0, 0, 2, "control");
        load_cc(3'b001);
        do_br(3'b100, 16'h3050, 1, 3'b100, 2, 1, 0, 5, "hold2");

        // Reset while in WAIT
        br_valid = 1'b1; br_mask = 3'b111; br_target = 16'h3060;
        ld_cc_req = 1'b1; cc_bus = 3'b010;
        chk("abort_ready", br_ready, 1);
        step();
        br_valid = 1'b0; ld_cc_req = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_ready_after", br_ready, 1);
        chk("abort_br_cnt", br_cnt, 0);
        chk("abort_taken_cnt", taken_cnt, 0);
        chk("abort_pc_next", pc_next, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", br_done, 0);
            step();
        end

        // br_valid held across RESP
        load_cc(3'b100);
        br_valid = 1'b1; br_mask = 3'b100; br_target = 16'h3070;
        first_done = -1; second_done = -1; n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (br_done) begin
                if (n_done == 0) first_done = i;
                else if (n_done == 1) second_done = i;
                n_done++;
            end
        end
        br_valid = 1'b0;
        step(); step(); step();
        chk("b2b_two_dones", n_done >= 2, 1);
        chk("b2b_spacing_ge3", (second_done - first_done) >= 3, 1);

        do_br(3'b000, 16'h3080, 0, 3'b000, 0, 0, 0, 2, "nop");

        // Saturation with 4-bit counters
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_cc(3'b010);
        for (int i = 1; i <= 17; i++) begin
            do_br(3'b111, 16'h4000 + 16'(i), 0, 3'b000, 0, 1, 0, 2, "sat");
            if (i == 14) chk("sat_cnt_14", br_cnt, 4'hE);
            if (i == 15) begin
                chk("sat_cnt_15", br_cnt, 4'hF);
                chk("sat_taken_15", taken_cnt, 4'hF);
            end
        end
        chk("sat_cnt_17", br_cnt, 4'hF);
        chk("sat_taken_17", taken_cnt, 4'hF);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/br_resolve_ctrl.md
# br_resolve_ctrl

Branch-resolution controller for the SLC-3 datapath. It owns the load-enable of the NZP condition-code register and sequences BR instructions against it. A BR request is evaluated only after any in-flight condition-code update has landed. The block then returns a taken/not-taken decision, a PC-load strobe and the branch target to the main control FSM, and keeps saturating branch statistics.

## Interface
- CNT_W, default 16: width of the statistics counters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock with reset high returns the block to its reset state.
- ld_cc_req  in  1  control FSM requests a condition-code update this cycle; the bus holds the DR value.
- ld_cc  out  1  load enable to the NZP register; combinational, equals ld_cc_req & ~reset.
- cc  in  3  NZP register output {n,z,p}.
- br_valid  in  1  BR request valid.
- br_ready  out  1  controller can accept a request.
- br_mask  in  3  IR[11:9] {n,z,p} mask; sampled on accept.
- br_target  in  16  PC + SEXT(offset9); sampled on accept.
- br_done  out  1  one-cycle pulse: the decision is valid.
- br_taken  out  1  decision; valid only while br_done is high, 0 otherwise.
- pc_ld  out  1  PC load strobe; equals br_done & br_taken.
- pc_next  out  16  captured target; held stable from accept until the next accept.
- cc_err  out  1  pulses with br_done when the sampled cc was not one-hot.
- br_cnt  out  CNT_W  branches resolved; saturates at all-ones.
- taken_cnt  out  CNT_W  branches taken; saturates at all-ones.

## Operation
- States: IDLE, WAIT, EVAL, RESP.
- IDLE: br_ready = 1. Accept occurs when br_valid & br_ready; the block captures br_mask and br_target.
  - If ld_cc_req = 1 in the accept cycle, go to WAIT, because cc is stale until the next edge.
  - Otherwise go to EVAL.
- WAIT: br_ready = 0. Go to EVAL next cycle.
  - If ld_cc_req = 1 again while in WAIT, stay in WAIT (the wait restarts).
- EVAL: sample cc.
  - Register taken = |(mask & cc).
  - Register err = (cc not in {100, 010, 001}).
  - Go to RESP.
  - A ld_cc_req in EVAL has no effect on this branch; the sampled value is used.
- RESP: br_done = 1, br_taken = taken, pc_ld = taken, cc_err = err.
  - br_cnt increments; taken_cnt increments if taken.
  - Go to IDLE. br_ready = 0 in this cycle, so back-to-back accepts are spaced by at least 3 cycles.
- Mask rules:
  - Mask 000: never taken (NOP).
  - Mask 111: always taken when cc is one-hot.
  - cc = 000, the NZP register reset value: never taken, and cc_err = 1.
- ld_cc is passed through in every state. The controller never blocks a CC write.
- br_valid while br_ready = 0 is ignored; the requester must hold it until accepted.

## Timing
- Reset values:
  - state = IDLE, so br_ready = 1 from the first cycle after reset.
  - br_done, br_taken, pc_ld, cc_err = 0.
  - pc_next = 16'h0000.
  - br_cnt, taken_cnt = 0.
  - captured mask = 000.
- Latency from the accept edge T: br_done at T+2 with no hazard, or T+3 when ld_cc_req coincides with accept. Add 1 cycle for each extra ld_cc_req held in WAIT.
- Reset mid-operation (any state): the next cycle is IDLE with all reset values. No br_done is issued for the aborted branch.
- Counter saturation: at all-ones the counter holds. br_cnt and taken_cnt saturate independently.
- All outputs except ld_cc are registered.

## Structure
- Shared package slc3_br_pkg holds:
  - the state enum (IDLE, WAIT, EVAL, RESP);
  - the NZP bit-index constants N_BIT = 2, Z_BIT = 1, P_BIT = 0;
  - the localparams for the one-hot cc codes.
- One sub-module is natural: sat_counter, parameterised by width, with an inc input. It is instantiated twice, for br_cnt and taken_cnt.
- The FSM and capture registers live in br_resolve_ctrl.

## Test plan
- Reset released with cc = 000, then BR with mask 111, target 16'h3010 → br_done at T+2 with br_taken = 0, pc_ld = 0, cc_err = 1; br_cnt = 1, taken_cnt = 0.
- CC load with cc going to 010, then BRz (mask 010), target 16'h3020, accepted 2 cycles later → br_done at T+2, br_taken = 1, pc_ld = 1, pc_next = 16'h3020, cc_err = 0.
- Hazard: cc = 001, and BRn (100) is accepted in the same cycle as ld_cc_req with the bus negative, so cc becomes 100 → WAIT is entered, br_done at T+3, br_taken = 1. Control case: without the coincident ld_cc_req the branch resolves not taken at T+2.
- Reset asserted for one cycle while in WAIT → br_done never pulses, br_ready = 1 the next cycle, counters = 0, pc_next = 16'h0000.
- br_valid held high across RESP → no second accept until IDLE; the second br_done arrives ≥3 cycles after the first. br_mask = 000 with any one-hot cc is never taken.
- CNT_W = 4 with 17 taken branches → br_cnt = taken_cnt = 4'hF, held after the 15th branch.
